// File: rtl/sextium_io_port.sv
// Responder end of the Sextium core IO bus: acknowledges core reads/writes and
// buffers words through TX/RX FIFOs exposed as valid/ready streams.
module sextium_io_port #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [WIDTH-1:0]      io_bus_in,
  output logic [WIDTH-1:0]      io_bus_out,
  output logic                  ioack,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [DEPTH_LOG2:0]   rx_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACK     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0] state, state_next;

  logic [WIDTH-1:0]      tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [WIDTH-1:0]      rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_not_full, rx_not_empty;

  // Flags come straight from the count flops, so a full FIFO popped this
  // cycle still refuses the push until the next cycle.
  assign tx_not_full  = (tx_count != FULL);
  assign rx_not_empty = (rx_count != '0);

  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign rx_ready = (rx_count != FULL);

  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;

  assign ioack = (state == ACK);

  always_comb begin
    state_next = state;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (io_write && !io_read && tx_not_full) begin
          tx_push    = 1'b1;
          state_next = ACK;
        end else if (io_read && !io_write && rx_not_empty) begin
          rx_pop     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = RELEASE;
      RELEASE: if (!io_read && !io_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      io_bus_out <= '0;
    end else begin
      state <= state_next;
      if (rx_pop) io_bus_out <= rx_mem[rx_rd_ptr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= io_bus_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_sextium_io_port.sv
// Scoreboard bench for sextium_io_port: queues of expected words, a negedge
// monitor that checks device-side and core-side outputs, and directed + random stimulus.
module tb_sextium_io_port;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [15:0] io_bus_in = '0;
  logic [15:0] io_bus_out;
  logic        ioack;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ack_cnt = 0;
  logic [15:0] tx_exp[$];
  logic [15:0] rx_exp[$];
  bit          cur_read = 1'b0;
  logic        prev_ack = 1'b0;
  bit          core_done = 1'b0;

  sextium_io_port #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
    .clock(clock), .reset(reset),
    .io_read(io_read), .io_write(io_write),
    .io_bus_in(io_bus_in), .io_bus_out(io_bus_out), .ioack(ioack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares outputs against the queues whenever the DUT presents data.
  always @(negedge clock) begin
    if (reset) begin
      if (ioack) begin
        ack_cnt++;
        chk("ack_width", {31'd0, prev_ack}, 32'd0);
        if (cur_read) begin
          if (rx_exp.size() == 0) fail_now("read_without_rx_word");
          else chk("read_data", {16'd0, io_bus_out}, {16'd0, rx_exp.pop_front()});
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) fail_now("tx_extra_word");
        else chk("tx_data", {16'd0, tx_data}, {16'd0, tx_exp.pop_front()});
      end
      if (rx_valid && rx_ready) rx_exp.push_back(rx_data);
      prev_ack = ioack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic core_req(input bit wr, input logic [15:0] d, input int unsigned limit,
                          output int unsigned lat);
    @(posedge clock); #1;
    cur_read = !wr;
    if (wr) begin
      io_write  = 1'b1;
      io_bus_in = d;
      tx_exp.push_back(d);
    end else begin
      io_read = 1'b1;
    end
    lat = 0;
    for (int unsigned k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (ioack) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) fail_now(wr ? "write_ack_timeout" : "read_ack_timeout");
  endtask

  task automatic core_release(input int unsigned hold);
    repeat (hold) @(posedge clock);
    @(posedge clock); #1;
    io_write = 1'b0;
    io_read  = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic dev_push(input logic [15:0] d);
    @(posedge clock); #1;
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ioack"},    {31'd0, ioack},      32'd0);
    chk({tag, "_bus_out"},  {16'd0, io_bus_out}, 32'd0);
    chk({tag, "_tx_count"}, {28'd0, tx_count},   32'd0);
    chk({tag, "_rx_count"}, {28'd0, rx_count},   32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid},   32'd0);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready},   32'd1);
  endtask

  int unsigned lat;
  int unsigned lat_rd;
  int unsigned a;
  bit          wr;

  initial begin
    // Reset, partial fill, then asynchronous reset aborting a pending write.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_cleared("rst0");

    for (int unsigned i = 0; i < 3; i++) begin
      core_req(1'b1, 16'h0100 + 16'(i), 10, lat);
      chk("fill_wr_lat", lat, 2);
      core_release(0);
    end
    dev_push(16'hC001);
    dev_push(16'hC002);
    core_req(1'b0, '0, 10, lat);
    chk("fill_rd_lat", lat, 2);
    core_release(0);
    chk("fill_tx_count", {28'd0, tx_count}, 32'd3);
    chk("fill_rx_count", {28'd0, rx_count}, 32'd1);
    @(posedge clock); #1;
    cur_read  = 1'b0;
    io_write  = 1'b1;
    io_bus_in = 16'hDEAD;
    #2 reset = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    #1 check_cleared("rst1");
    io_write = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    a = ack_cnt;
    repeat (4) @(posedge clock);
    chk("rst_no_ack", ack_cnt, a);
    chk("rst_tx_empty", {28'd0, tx_count}, 32'd0);

    // Two writes with the device stalled, then drain.
    core_req(1'b1, 16'h1234, 10, lat); chk("w1234_lat", lat, 2); core_release(0);
    core_req(1'b1, 16'hBEEF, 10, lat); chk("wbeef_lat", lat, 2); core_release(0);
    chk("two_tx_count", {28'd0, tx_count}, 32'd2);
    chk("two_tx_head",  {16'd0, tx_data},  32'h1234);
    @(posedge clock); #1 tx_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 tx_ready = 1'b0;
    chk("two_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("two_drained", tx_exp.size(), 0);

    // Fill TX, stall the ninth write, release it with a single-cycle pulse.
    for (int unsigned i = 1; i <= 8; i++) begin
      core_req(1'b1, 16'(i), 10, lat);
      chk("full_wr_lat", lat, 2);
      core_release(0);
    end
    chk("full_tx_count", {28'd0, tx_count}, 32'd8);
    chk("full_tx_head",  {16'd0, tx_data},  32'h0001);
    a = ack_cnt;
    fork
      core_req(1'b1, 16'h0009, 30, lat);
      begin
        repeat (12) @(posedge clock);
        chk("full_stall_no_ack", ack_cnt, a);
        #1 tx_ready = 1'b1;
        @(posedge clock); #1 tx_ready = 1'b0;
      end
    join
    chk("full_release_lat", lat, 14);
    core_release(0);
    chk("full_tx_count_again", {28'd0, tx_count}, 32'd8);
    @(posedge clock); #1 tx_ready = 1'b1;
    repeat (12) @(posedge clock);
    #1 tx_ready = 1'b0;
    chk("full_drained", tx_exp.size(), 0);
    chk("full_tx_zero", {28'd0, tx_count}, 32'd0);

    // Read while RX empty; device supplies a word after 20 cycles.
    a = ack_cnt;
    fork
      core_req(1'b0, '0, 40, lat);
      begin
        repeat (20) @(posedge clock);
        chk("rd_stall_no_ack", ack_cnt, a);
        #1 rx_valid = 1'b1; rx_data = 16'hA5A5;
        @(posedge clock); #1 rx_valid = 1'b0;
      end
    join
    chk("rd_stall_lat", lat, 22);
    chk("rd_stall_data", {16'd0, io_bus_out}, 32'h0000A5A5);
    core_release(0);
    chk("rd_stall_rx_count", {28'd0, rx_count}, 32'd0);

    // Held write acked once; simultaneous read+write ignored.
    a = ack_cnt;
    core_req(1'b1, 16'h5555, 10, lat);
    chk("hold_lat", lat, 2);
    core_release(5);
    chk("hold_one_ack", ack_cnt, a + 1);
    chk("hold_one_push", {28'd0, tx_count}, 32'd1);
    dev_push(16'h7777);
    chk("illegal_rx_pre", {28'd0, rx_count}, 32'd1);
    @(posedge clock); #1;
    io_read = 1'b1; io_write = 1'b1; io_bus_in = 16'hFFFF;
    a = ack_cnt;
    repeat (10) @(posedge clock);
    #1;
    chk("illegal_no_ack", ack_cnt, a);
    chk("illegal_tx_count", {28'd0, tx_count}, 32'd1);
    chk("illegal_rx_count", {28'd0, rx_count}, 32'd1);
    io_read = 1'b0; io_write = 1'b0;
    repeat (2) @(posedge clock);
    #1 tx_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 tx_ready = 1'b0;
    core_req(1'b0, '0, 10, lat); chk("illegal_rd_lat", lat, 2); core_release(0);

    // Simultaneous RX push and pop keep the count.
    dev_push(16'h0201); dev_push(16'h0202); dev_push(16'h0203);
    chk("sim_rx_pre", {28'd0, rx_count}, 32'd3);
    fork
      core_req(1'b0, '0, 10, lat_rd);
      begin
        @(posedge clock); #1 rx_valid = 1'b1; rx_data = 16'h0404;
        @(posedge clock); #1 rx_valid = 1'b0;
      end
    join
    chk("sim_rd_lat", lat_rd, 2);
    chk("sim_rx_count", {28'd0, rx_count}, 32'd3);
    core_release(0);

    // Random bidirectional stream.
    fork
      begin
        for (int unsigned i = 0; i < 200; i++) begin
          wr = ($urandom_range(0, 1) == 1);
          core_req(wr, 16'($urandom), 300, lat);
          core_release($urandom_range(0, 2));
        end
        core_done = 1'b1;
      end
      begin
        while (!core_done) begin
          @(posedge clock); #1;
          tx_ready = ($urandom_range(0, 1) == 1);
          rx_valid = ($urandom_range(0, 1) == 1);
          rx_data  = 16'($urandom);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (20) @(posedge clock);
        #1 tx_ready = 1'b0;
      end
    join
    @(negedge clock);
    chk("rand_tx_drained", tx_exp.size(), 0);
    chk("rand_tx_count", {28'd0, tx_count}, 32'd0);
    chk("rand_rx_count", {28'd0, rx_count}, rx_exp.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
